conv_layer_input_ctrl: RTL and testbench



---
 rtl/conv_layer_pkg.sv | 31 +++
 rtl/conv_layer_input_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_conv_layer_input_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_layer_pkg.sv
// Shared types for the conv layer: cmd/ack handshake codes, input controller states, float constants.
package conv_layer_pkg;

    typedef enum logic [1:0] {
        CMD_IDLE          = 2'd0,
        CMD_PRELOAD_START = 2'd1,
        CMD_SHIFT_START   = 2'd2,
        CMD_LOAD_START    = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        ACK_IDLE        = 2'd0,
        ACK_PRELOAD_FIN = 2'd1,
        ACK_SHIFT_FIN   = 2'd2,
        ACK_LOAD_FIN    = 2'd3
    } ack_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRE_REQ  = 3'd1,
        ST_PRE_WAIT = 3'd2,
        ST_SH_REQ   = 3'd3,
        ST_SH_WAIT  = 3'd4,
        ST_LD_REQ   = 3'd5,
        ST_LD_WAIT  = 3'd6,
        ST_FIN      = 3'd7
    } ctrl_state_t;

    localparam logic [31:0] FLOAT32_ONE = 32'h3F80_0000;

endpackage

// File: rtl/conv_layer_input_ctrl.sv
// Frame sequencer for the conv input interface: PRELOAD, then SHIFT/LOAD per output row.
// Optional ack watchdog enabled by defining CONV_IN_CTRL_WATCHDOG_EN.
module conv_layer_input_ctrl
    import conv_layer_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE  = 8,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned ROW_W       = 3
`ifdef CONV_IN_CTRL_WATCHDOG_EN
    ,
    parameter int unsigned WDOG_CYCLES = 64
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic [1:0]       ack,
    output logic [1:0]       cmd,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic [ROW_W-1:0] row_idx,
    output logic             row_valid,
    output logic             err
);

    localparam int unsigned LAST_ROW = IMAGE_SIZE - KERNEL_SIZE;

    ctrl_state_t      state_q, state_d;
    cmd_t             cmd_q, cmd_d;
    logic             enable_q, enable_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             row_valid_q, row_valid_d;
    logic [ROW_W-1:0] row_idx_q, row_idx_d;
    ack_t             ack_c;
    logic             ack_match_c;

    assign ack_c = ack_t'(ack);

    // A wait state only advances on its own completion code.
    assign ack_match_c = ((state_q == ST_PRE_WAIT) && (ack_c == ACK_PRELOAD_FIN)) ||
                         ((state_q == ST_SH_WAIT)  && (ack_c == ACK_SHIFT_FIN))   ||
                         ((state_q == ST_LD_WAIT)  && (ack_c == ACK_LOAD_FIN));

`ifdef CONV_IN_CTRL_WATCHDOG_EN
    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              err_q, err_d;
    logic              in_wait_c;

    assign in_wait_c = (state_q == ST_PRE_WAIT) || (state_q == ST_SH_WAIT) ||
                       (state_q == ST_LD_WAIT);
`endif

    always_comb begin
        state_d     = state_q;
        cmd_d       = CMD_IDLE;
        enable_d    = enable_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        row_valid_d = 1'b0;
        row_idx_d   = row_idx_q;
`ifdef CONV_IN_CTRL_WATCHDOG_EN
        err_d       = err_q;
        wdog_d      = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_PRE_REQ;
                    busy_d    = 1'b1;
                    enable_d  = 1'b1;
                    row_idx_d = '0;
                end
            end
            ST_PRE_REQ: begin
                if (!pause) begin
                    cmd_d   = CMD_PRELOAD_START;
                    state_d = ST_PRE_WAIT;
                end
            end
            ST_PRE_WAIT: begin
                if (ack_match_c) state_d = ST_SH_REQ;
            end
            ST_SH_REQ: begin
                if (!pause) begin
                    cmd_d   = CMD_SHIFT_START;
                    state_d = ST_SH_WAIT;
                end
            end
            ST_SH_WAIT: begin
                if (ack_match_c) begin
                    row_valid_d = 1'b1;
                    if (row_idx_q == ROW_W'(LAST_ROW)) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_LD_REQ;
                    end
                end
            end
            ST_LD_REQ: begin
                if (!pause) begin
                    cmd_d   = CMD_LOAD_START;
                    state_d = ST_LD_WAIT;
                end
            end
            ST_LD_WAIT: begin
                if (ack_match_c) begin
                    state_d   = ST_SH_REQ;
                    row_idx_d = row_idx_q + 1'b1;
                end
            end
            ST_FIN: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                enable_d = 1'b0;
            end
        endcase
`ifdef CONV_IN_CTRL_WATCHDOG_EN
        // Abandon the frame if an ack never arrives; err stays set until reset.
        if (in_wait_c && !ack_match_c) begin
            if (wdog_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = ST_FIN;
                done_d  = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_IDLE;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            row_valid_q <= row_valid_d;
            row_idx_q   <= row_idx_d;
        end
    end

`ifdef CONV_IN_CTRL_WATCHDOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign cmd       = cmd_q;
    assign enable    = enable_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign row_idx   = row_idx_q;
    assign row_valid = row_valid_q;

endmodule

// File: tb/tb_conv_layer_input_ctrl.sv
// Scoreboard bench for conv_layer_input_ctrl: acking interface model, pause, wrong ack,
// ignored starts and mid-frame reset, with a monitor comparing cmd/row/done events in order.
module tb_conv_layer_input_ctrl;

    localparam int LAST_ROW = 5;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       pause;
    logic [1:0] ack;
    logic [1:0] cmd;
    logic       enable;
    logic       busy;
    logic       done;
    logic [2:0] row_idx;
    logic       row_valid;
    logic       err;

    int total = 0;
    int bad   = 0;

    int exp_cmd_q[$];
    int exp_row_q[$];
    int exp_done_q[$];

    bit pause_en  = 0;
    bit wrong_en  = 0;
    bit ld4_seen  = 0;
    int shift_n   = 0;
    int load_n    = 0;
    event ev_pause;

    conv_layer_input_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .ack       (ack),
        .cmd       (cmd),
        .enable    (enable),
        .busy      (busy),
        .done      (done),
        .row_idx   (row_idx),
        .row_valid (row_valid),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input int act);
        total++;
        bad++;
        $display("FAIL %s: got %0d with nothing expected at %0t", name, act, $time);
    endtask

    // Expected event stream for a frame that shifts `rows` rows; full frames end with done.
    task automatic push_exp(input int rows, input bit full);
        exp_cmd_q.push_back(1);
        for (int r = 0; r < rows; r++) begin
            exp_cmd_q.push_back(2);
            exp_row_q.push_back(r);
            if (!(full && r == rows - 1)) exp_cmd_q.push_back(3);
        end
        if (full) exp_done_q.push_back(LAST_ROW);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_cmd_left"}, exp_cmd_q.size(), 0);
        check({tag, "_row_left"}, exp_row_q.size(), 0);
        check({tag, "_done_left"}, exp_done_q.size(), 0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_cmd"}, int'(cmd), 0);
        check({tag, "_enable"}, int'(enable), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_row_idx"}, int'(row_idx), 0);
        check({tag, "_row_valid"}, int'(row_valid), 0);
        check({tag, "_err"}, int'(err), 0);
    endtask

    task automatic run_frame(input string tag, input bit mid_start, input bit done_start);
        bit busy_ok;
        bit got_done;
        busy_ok  = 1'b1;
        got_done = 1'b0;
        push_exp(LAST_ROW + 1, 1'b1);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_on"}, int'(busy), 1);
        check({tag, "_enable_on"}, int'(enable), 1);
        check({tag, "_row_idx_start"}, int'(row_idx), 0);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = (mid_start && i == 20);
            if (done) begin
                got_done = 1'b1;
                check({tag, "_busy_at_done"}, int'(busy), 1);
                start = done_start;
                @(negedge clk);
                start = 1'b0;
                check({tag, "_busy_off"}, int'(busy), 0);
                check({tag, "_enable_off"}, int'(enable), 0);
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        check({tag, "_done_seen"}, int'(got_done), 1);
        check({tag, "_busy_held"}, int'(busy_ok), 1);
        repeat (5) @(negedge clk);
        check({tag, "_idle_busy"}, int'(busy), 0);
        check_drained(tag);
    endtask

    // Scoreboard monitor: every DUT event must match the next expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (cmd != 2'd0) begin
                if (exp_cmd_q.size() == 0) unexpected("cmd_unexpected", int'(cmd));
                else check("cmd_seq", int'(cmd), exp_cmd_q.pop_front());
            end
            if (row_valid) begin
                if (exp_row_q.size() == 0) unexpected("row_valid_unexpected", int'(row_idx));
                else check("row_valid_idx", int'(row_idx), exp_row_q.pop_front());
            end
            if (done) begin
                if (exp_done_q.size() == 0) unexpected("done_unexpected", int'(row_idx));
                else check("done_row", int'(row_idx), exp_done_q.pop_front());
            end
        end
    end

    // Input interface model: acks each command three cycles after it appears.
    initial begin
        logic [1:0] c;
        ack = 2'd0;
        forever begin
            @(negedge clk);
            if (rst_n && cmd != 2'd0) begin
                c = cmd;
                if (c == 2'd1) begin
                    shift_n = 0;
                    load_n  = 0;
                end else if (c == 2'd2) begin
                    shift_n++;
                end else begin
                    load_n++;
                    if (load_n == 4) ld4_seen = 1'b1;
                end
                @(negedge clk);
                @(negedge clk);
                if (rst_n) begin
                    if (wrong_en && c == 2'd2 && shift_n == 4) begin
                        ack = 2'd3;
                        @(negedge clk);
                        ack = 2'd0;
                        check("wrong_ack_row_valid", int'(row_valid), 0);
                        @(negedge clk);
                        check("wrong_ack_cmd", int'(cmd), 0);
                    end
                    if (pause_en && c == 2'd3 && load_n == 2) -> ev_pause;
                    ack = c;
                    @(negedge clk);
                    ack = 2'd0;
                end
            end
        end
    end

    // Holds pause across ten SH_REQ edges for row 2, then expects SHIFT_START right after release.
    initial begin
        pause = 1'b0;
        forever begin
            @(ev_pause);
            pause = 1'b1;
            repeat (11) begin
                @(negedge clk);
                check("pause_cmd_hold", int'(cmd), 0);
            end
            pause = 1'b0;
            @(negedge clk);
            check("pause_release_cmd", int'(cmd), 2);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_frame("nominal", 1'b0, 1'b0);

        pause_en = 1'b1;
        run_frame("pause", 1'b0, 1'b0);
        pause_en = 1'b0;

        wrong_en = 1'b1;
        run_frame("wrong_ack_starts", 1'b1, 1'b1);
        wrong_en = 1'b0;

        run_frame("after_ignored", 1'b0, 1'b0);

        // Reset during LD_WAIT of row 3.
        ld4_seen = 1'b0;
        push_exp(4, 1'b0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (ld4_seen) break;
            @(negedge clk);
        end
        check("rst_ld4_reached", int'(ld4_seen), 1);
        check("rst_row_before", int'(row_idx), 3);
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        repeat (3) @(negedge clk);
        check_reset_vals("held_rst");
        rst_n = 1'b1;
        check_drained("rst_frame");
        repeat (4) @(negedge clk);

        run_frame("post_reset", 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
